// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   op_e    : operation select encodings seen on the op port
//   state_e : sequencer states, also visible on the dbg_state port
//   CNT_W   : iteration counter width for the default 32-bit build
package mdu_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int CNT_W     = $clog2(DEF_WIDTH) + 1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    SIGN = 2'b10,
    DONE = 2'b11
  } state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the multiply/divide datapath, purely combinational.
// Ports:
//   is_div : 1 selects restoring shift-subtract, 0 selects shift-add
//   acc_i  : MUL {partial product hi, multiplier bits}; DIV low half is the
//            dividend being shifted out / quotient being shifted in
//   rem_i  : DIV partial remainder (always < divisor, so WIDTH bits hold it)
//   opb_i  : multiplicand (MUL) or divisor (DIV), magnitudes
//   acc_o, rem_o : values after this iteration
module mdu_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     rem_i,
  input  logic [WIDTH-1:0]     opb_i,
  output logic [2*WIDTH-1:0]   acc_o,
  output logic [WIDTH-1:0]     rem_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_part;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;

  always_comb begin
    // MUL: add multiplicand into the upper half when the current multiplier
    // bit is set, then shift the whole accumulator right by one (carry kept).
    mul_sum  = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : '0);
    // DIV: the trial remainder needs WIDTH+1 bits before the subtract.
    div_part = {rem_i, acc_i[WIDTH-1]};
    div_ge   = (div_part >= {1'b0, opb_i});
    // When div_ge holds the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    div_diff = div_part[WIDTH-1:0] - opb_i;

    acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    rem_o = rem_i;
    if (is_div) begin
      acc_o = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-2:0], div_ge};
      rem_o = div_ge ? div_diff : div_part[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_hilo_writer.sv
// Iterative MULT/MULTU/DIV/DIVU unit and write port for the HI and LO
// register files. Signed operands are reduced to magnitudes, WIDTH
// iterations run in CALC, the sign is restored in SIGN and the result is
// written during the single DONE cycle.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, op, flush    : request (sampled in IDLE), op select, abort
//   rs_data, rt_data    : multiplicand/dividend, multiplier/divisor
//   busy, done          : busy in CALC/SIGN/DONE; done pulses with the write
//   hi_we/hi_wdata      : HI write port (product upper half or remainder)
//   lo_we/lo_wdata      : LO write port (product lower half or quotient)
//   dbg_state           : current sequencer state (state_e encoding)
// Handshake: start is taken only when the unit is IDLE and flush is low;
// starts seen while busy are dropped. done/hi_we/lo_we are asserted together
// for exactly one cycle unless flush is high in that same cycle.
module mdu_hilo_writer
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             flush,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             hi_we,
  output logic [WIDTH-1:0] hi_wdata,
  output logic             lo_we,
  output logic [WIDTH-1:0] lo_wdata,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               neg_quo_q, neg_quo_d;   // quotient/product must be negated
  logic               neg_rem_q, neg_rem_d;   // remainder takes the dividend's sign
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic [2*WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0]   rem_nxt;

  logic               in_signed, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_mag, rt_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  mdu_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div (op_q[1]),
    .acc_i  (acc_q),
    .rem_i  (rem_q),
    .opb_i  (opb_q),
    .acc_o  (acc_nxt),
    .rem_o  (rem_nxt)
  );

  always_comb begin
    in_signed = ~op[0];
    rs_neg    = in_signed & rs_data[WIDTH-1];
    rt_neg    = in_signed & rt_data[WIDTH-1];
    rs_mag    = rs_neg ? -rs_data : rs_data;
    rt_mag    = rt_neg ? -rt_data : rt_data;

    prod_fix = neg_quo_q ? -acc_q : acc_q;
    // Divide by zero: the core already yields quotient all-ones and remainder
    // |rs|. Quotient sign fix is skipped; the remainder fix turns |rs| back
    // into the latched rs value.
    quo_fix  = (opb_q == '0) ? '1 :
               (neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_rem_q ? -rem_q : rem_q;

    state_d   = state_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    opb_d     = opb_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_d      = op;
            neg_quo_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            // DIV keeps the dividend in the accumulator and the divisor in opb;
            // MUL keeps the multiplier in the accumulator and multiplicand in opb.
            opb_d     = op[1] ? rt_mag : rs_mag;
            acc_d     = {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
            rem_d     = '0;
            cnt_d     = '0;
            state_d   = CALC;
          end
        end
        CALC: begin
          acc_d = acc_nxt;
          rem_d = rem_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(WIDTH - 1)) state_d = SIGN;
        end
        SIGN: begin
          if (op_q[1]) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      rem_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      opb_q     <= opb_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // A flush during DONE suppresses the write in that very cycle.
  assign done      = (state_q == DONE) && !flush;
  assign hi_we     = done;
  assign lo_we     = done;
  assign busy      = (state_q != IDLE);
  assign hi_wdata  = hi_q;
  assign lo_wdata  = lo_q;
  assign dbg_state = state_q;

endmodule
